// File: rtl/spi_pkg.sv
// spi_pkg: shared constants and FSM state type for the SPI master.
package spi_pkg;
  localparam int SPI_FRAME_BITS = 32;
  localparam int SPI_MIN_CLOCK_DIVIDER = 4;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} spi_state_e;
endpackage

// File: rtl/spi_master_if.sv
// spi_master_if: command handshake, sample return and SPI pins of the SPI master.
interface spi_master_if;
  logic i_CommandValid;
  logic o_CommandReady;
  logic [15:0] i_CommandNumber;
  logic [15:0] i_CommandValue;
  logic o_SampleValid;
  logic [15:0] o_Sample;
  logic o_SPI_NSS;
  logic o_SPI_SCK;
  logic o_SPI_MOSI;
  logic i_SPI_MISO;
  modport master (
    input i_CommandValid, i_CommandNumber, i_CommandValue, i_SPI_MISO,
    output o_CommandReady, o_SampleValid, o_Sample, o_SPI_NSS, o_SPI_SCK, o_SPI_MOSI
  );
  modport slave (
    output i_CommandValid, i_CommandNumber, i_CommandValue, i_SPI_MISO,
    input o_CommandReady, o_SampleValid, o_Sample, o_SPI_NSS, o_SPI_SCK, o_SPI_MOSI
  );
endinterface

// File: rtl/spi_master_clkdiv.sv
// spi_master_clkdiv: half-period counter, one-cycle tick every D cycles, restarted by clr.
module spi_master_clkdiv #(
  parameter int D = 4
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(D);
  localparam logic [W-1:0] LAST = W'(D - 1);
  logic [W-1:0] cnt;
  always_ff @(posedge i_Clock)
    cnt <= (i_Reset || clr || tick) ? '0 : cnt + 1'b1;
  assign tick = cnt == LAST;
endmodule

// File: rtl/spi_master.sv
// spi_master: 32-bit MSB-first SPI command writer; define SPI_MASTER_READBACK_EN to capture MISO into o_Sample.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLOCK_DIVIDER = 4
) (
  input logic i_Clock,
  input logic i_Reset,
  spi_master_if.master bus
);
  if (CLOCK_DIVIDER < SPI_MIN_CLOCK_DIVIDER) begin : g_div_check
    $error("spi_master: CLOCK_DIVIDER must be >= %0d", SPI_MIN_CLOCK_DIVIDER);
  end
  spi_state_e state, next;
  logic tick, sck, nss, last_pulse, sck_rise;
  logic [5:0] bit_cnt;
  logic [SPI_FRAME_BITS-1:0] frame;
  spi_master_clkdiv #(.D(CLOCK_DIVIDER)) u_clkdiv (
    .i_Clock(i_Clock),
    .i_Reset(i_Reset),
    .clr(next != state),
    .tick(tick)
  );
  assign last_pulse = bit_cnt == 6'd31;
  // Pulses 2..32 start here: MOSI advances and MISO is taken on the same edge.
  assign sck_rise = state == SHIFT && tick && !sck && !last_pulse;
  always_comb begin
    next = state;
    next = state == IDLE  ? (bus.i_CommandValid ? SETUP : IDLE) :
           state == SETUP ? (tick ? SHIFT : SETUP) :
           state == SHIFT ? ((tick && !sck && last_pulse) ? HOLD : SHIFT) :
           state == HOLD  ? (tick ? GAP : HOLD) :
                            (tick ? IDLE : GAP);
  end
  always_ff @(posedge i_Clock)
    state <= i_Reset ? IDLE : next;
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      sck <= 1'b0;
      bit_cnt <= '0;
      frame <= '0;
    end else begin
      sck <= ((state == SETUP && tick) || sck_rise) ? 1'b1 : tick ? 1'b0 : sck;
      bit_cnt <= state == IDLE ? 6'd0 : sck_rise ? bit_cnt + 6'd1 : bit_cnt;
      frame <= (state == IDLE && bus.i_CommandValid) ? {bus.i_CommandNumber, bus.i_CommandValue} :
               sck_rise ? {frame[SPI_FRAME_BITS-2:0], 1'b0} : frame;
    end
  end
  assign nss = state == IDLE || state == GAP;
  assign bus.o_CommandReady = state == IDLE;
  assign bus.o_SPI_NSS = nss;
  assign bus.o_SPI_SCK = sck;
  assign bus.o_SPI_MOSI = !nss && frame[SPI_FRAME_BITS-1];
`ifdef SPI_MASTER_READBACK_EN
  logic hold_end;
  logic [15:0] cap, sample;
  logic sample_valid;
  assign hold_end = state == HOLD && tick;
  // Only the low half of the captured frame is ever reported, so only 16 bits are kept.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      cap <= '0;
      sample <= '0;
      sample_valid <= 1'b0;
    end else begin
      cap <= (sck_rise || hold_end) ? {cap[14:0], bus.i_SPI_MISO} : cap;
      sample <= hold_end ? {cap[14:0], bus.i_SPI_MISO} : sample;
      sample_valid <= hold_end;
    end
  end
  assign bus.o_Sample = sample;
  assign bus.o_SampleValid = sample_valid;
`else
  logic unused_miso;
  assign unused_miso = bus.i_SPI_MISO;
  assign bus.o_Sample = '0;
  assign bus.o_SampleValid = 1'b0;
`endif
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed scoreboard bench for spi_master with D = 4; MISO loops back to MOSI when readback is built in.
module tb_spi_master;
  localparam int D = 4;
`ifdef SPI_MASTER_READBACK_EN
  localparam int EXP_PULSES = 6;
`else
  localparam int EXP_PULSES = 0;
`endif
  logic i_Clock, i_Reset, tog;
  int total = 0, bad = 0;
  spi_master_if ifc();
  spi_master #(.CLOCK_DIVIDER(D)) dut (.i_Clock(i_Clock), .i_Reset(i_Reset), .bus(ifc.master));
`ifdef SPI_MASTER_READBACK_EN
  assign ifc.i_SPI_MISO = ifc.o_SPI_MOSI;
`else
  assign ifc.i_SPI_MISO = tog;
`endif
  initial begin
    i_Clock = 0;
    forever #5 i_Clock = ~i_Clock;
  end
  initial begin
    tog = 0;
    forever begin
      @(posedge i_Clock);
      #2 tog = ~tog;
    end
  end
  logic [31:0] exp_frame_q[$], frame_q[$];
  logic [15:0] exp_samp_q[$], samp_q[$];
  int pulse_q[$], low_q[$], gap_q[$];
  logic [31:0] rx;
  logic p_nss = 1, p_sck = 0, p_valid = 0, seen = 0;
  int pulses = 0, low = 0, high = 0, vcount = 0, vbad = 0, rbad = 0;
  always @(negedge i_Clock) begin
    if (!ifc.o_SPI_NSS) begin
      if (p_nss) begin
        if (seen) gap_q.push_back(high);
        rx = 0;
        pulses = 0;
        low = 0;
      end
      low++;
      if (ifc.o_SPI_SCK && !p_sck) pulses++;
      if (!ifc.o_SPI_SCK && p_sck) rx = {rx[30:0], ifc.o_SPI_MOSI};
    end else begin
      if (!p_nss) begin
        frame_q.push_back(rx);
        pulse_q.push_back(pulses);
        low_q.push_back(low);
        high = 0;
        seen = 1;
      end
      high++;
    end
    if (ifc.o_SampleValid) begin
      samp_q.push_back(ifc.o_Sample);
      vcount++;
      if (p_valid || p_nss || !ifc.o_SPI_NSS) vbad++;
    end
    if (ifc.o_CommandReady && (!ifc.o_SPI_NSS || ifc.o_SPI_SCK)) rbad++;
    p_nss = ifc.o_SPI_NSS;
    p_sck = ifc.o_SPI_SCK;
    p_valid = ifc.o_SampleValid;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_ready();
    logic ok = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge i_Clock);
      #1;
      ok = ifc.o_CommandReady;
    end
    chk("ready_wait", ok, 1);
  endtask
  task automatic wait_frames(input int n);
    logic ok = 0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge i_Clock);
      #1;
      ok = frame_q.size() >= n;
    end
    chk("frame_wait", ok, 1);
  endtask
  task automatic send(input logic [15:0] n, input logic [15:0] v, input bit push);
    wait_ready();
    ifc.i_CommandNumber = n;
    ifc.i_CommandValue = v;
    ifc.i_CommandValid = 1;
    if (push) begin
      exp_frame_q.push_back({n, v});
`ifdef SPI_MASTER_READBACK_EN
      exp_samp_q.push_back(v);
`endif
    end
    @(posedge i_Clock);
    #1 ifc.i_CommandValid = 0;
  endtask
  task automatic check_frames();
    logic [31:0] e;
    while (frame_q.size() > 0) begin
      e = exp_frame_q.size() > 0 ? exp_frame_q.pop_front() : 'x;
      chk("mosi_frame", frame_q.pop_front(), e);
      chk("sck_pulses", pulse_q.pop_front(), 32);
      chk("nss_low_cycles", low_q.pop_front(), 66 * D);
    end
    while (samp_q.size() > 0) begin
      e = exp_samp_q.size() > 0 ? {16'h0, exp_samp_q.pop_front()} : 'x;
      chk("sample", samp_q.pop_front(), e);
    end
  endtask
  initial begin
    int n;
    logic ok;
    logic [15:0] nums[3] = '{16'h1111, 16'h2222, 16'h3333};
    logic [15:0] vals[3] = '{16'hA001, 16'hB002, 16'hC003};
    i_Reset = 1;
    ifc.i_CommandValid = 0;
    ifc.i_CommandNumber = 0;
    ifc.i_CommandValue = 0;
    repeat (3) @(posedge i_Clock);
    #1 i_Reset = 0;
    chk("rst_nss", ifc.o_SPI_NSS, 1);
    chk("rst_sck", ifc.o_SPI_SCK, 0);
    chk("rst_mosi", ifc.o_SPI_MOSI, 0);
    chk("rst_ready", ifc.o_CommandReady, 1);
    chk("rst_sample_valid", ifc.o_SampleValid, 0);
    chk("rst_sample", ifc.o_Sample, 0);
    // Basic frame, then NSS stays high for exactly D cycles before ready.
    send(16'h0012, 16'hABCD, 1);
    wait_frames(1);
    n = 1;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge i_Clock);
      #1;
      ok = ifc.o_CommandReady;
      if (!ok) n++;
    end
    chk("gap_before_ready", n, D);
    check_frames();
    send(16'h1234, 16'h5678, 1);
    wait_frames(1);
    check_frames();
    // Valid held high across three commands; busy cycles must not consume data.
    ifc.i_CommandValid = 1;
    for (int k = 0; k < 3; k++) begin
      wait_ready();
      ifc.i_CommandNumber = nums[k];
      ifc.i_CommandValue = vals[k];
      exp_frame_q.push_back({nums[k], vals[k]});
`ifdef SPI_MASTER_READBACK_EN
      exp_samp_q.push_back(vals[k]);
`endif
      @(posedge i_Clock);
      #1;
    end
    ifc.i_CommandValid = 0;
    wait_frames(3);
    chk("b2b_gap_count", gap_q.size() >= 2, 1);
    if (gap_q.size() >= 2) begin
      chk("b2b_gap1", gap_q[gap_q.size() - 2], D + 1);
      chk("b2b_gap2", gap_q[gap_q.size() - 1], D + 1);
    end
    check_frames();
    // Inputs change right after the handshake; latched command must go out.
    send(16'h0001, 16'h0002, 1);
    ifc.i_CommandNumber = 16'hFFFF;
    ifc.i_CommandValue = 16'hFFFF;
    wait_frames(1);
    check_frames();
    // Reset in the middle of SHIFT.
    send(16'hA5A5, 16'h5A5A, 0);
    ok = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge i_Clock);
      #1;
      ok = pulses == 10 && !ifc.o_SPI_NSS;
    end
    chk("reach_bit10", ok, 1);
    i_Reset = 1;
    @(posedge i_Clock);
    #1 i_Reset = 0;
    chk("abort_nss", ifc.o_SPI_NSS, 1);
    chk("abort_sck", ifc.o_SPI_SCK, 0);
    chk("abort_mosi", ifc.o_SPI_MOSI, 0);
    chk("abort_ready", ifc.o_CommandReady, 1);
    chk("abort_sample", ifc.o_Sample, 0);
    repeat (300) @(negedge i_Clock);
    #1;
    chk("abort_no_pulse", samp_q.size(), 0);
    frame_q.delete();
    pulse_q.delete();
    low_q.delete();
    chk("sample_pulses", vcount, EXP_PULSES);
    chk("sample_pulse_timing", vbad, 0);
    chk("ready_only_idle", rbad, 0);
    chk("scoreboard_empty", exp_frame_q.size() + exp_samp_q.size(), 0);
    chk("final_sample", ifc.o_Sample, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_master.md
# spi_master

SPI master that serializes 32-bit register-write commands (16-bit register number, 16-bit value) onto MOSI and captures the 32 bits returned on MISO during the same frame. It drives the other end of the synthesizer's SPI slave link, framing commands exactly as the slave expects: MSB first, one command per NSS-low frame, bits taken on SCK falling edges. It is used as a bench/board-level initiator and for FPGA-to-FPGA register forwarding.

## Interface
- CLOCK_DIVIDER, 4, i_Clock cycles per SCK half-period; must be ≥ 4 so SCK is at least 8x slower than i_Clock.
- i_Clock  in  1  system clock.
- i_Reset  in  1  synchronous, active-high reset.
- i_CommandValid  in  1  command offered.
- o_CommandReady  out  1  block idle, command accepted this cycle if valid.
- i_CommandNumber  in  16  register number, sent first (frame bits 31:16).
- i_CommandValue  in  16  register value (frame bits 15:0).
- o_SampleValid  out  1  one-cycle pulse, o_Sample updated.
- o_Sample  out  16  low 16 bits of the last captured MISO frame.
- o_SPI_NSS  out  1  chip select, active low.
- o_SPI_SCK  out  1  serial clock, idle low.
- o_SPI_MOSI  out  1  serial data out.
- i_SPI_MISO  in  1  serial data in.

## Operation
- States: IDLE → SETUP → SHIFT → HOLD → GAP → IDLE.
- IDLE: o_CommandReady = 1, NSS high, SCK low. On valid && ready, latch {number, value} into a 32-bit shift register; go SETUP. Command inputs are ignored after the handshake.
- SETUP: NSS low, SCK low, MOSI = frame bit 31; lasts CLOCK_DIVIDER cycles.
- SHIFT: 32 SCK pulses, each high for D then low for D cycles (D = CLOCK_DIVIDER). MOSI advances to the next bit on the same cycle SCK rises for pulses 2..32, so it is stable across every falling edge.
- MISO capture: sampled on the cycle SCK rises for pulses 2..32 and on the last HOLD cycle, giving 32 bits shifted in MSB first.
- HOLD: SCK low, NSS low for D cycles. At the end, o_Sample <= capture[15:0] and o_SampleValid pulses.
- GAP: NSS high, SCK low for D cycles (guarantees slave resync); then IDLE.
- o_CommandReady is decoded from state == IDLE; it is never high in any other state.
- i_CommandValid while busy: no effect, the command is not consumed.
- Back-to-back commands: ready returns only after GAP; no frame overlap.
- Reset (any time, including mid-frame): next edge state = IDLE, NSS = 1, SCK = 0, MOSI = 0, o_SampleValid = 0, o_Sample = 0, capture cleared; the aborted frame produces no sample pulse.

## Timing
- Handshake at edge T: NSS low from T+1. SETUP is D cycles, SHIFT is 64·D cycles, HOLD is D cycles, so NSS is low for 66·D cycles, then high for D cycles in GAP.
- Accept-to-accept minimum: 67·D + 1 cycles (D = 4: 269).
- o_SampleValid fires on the last NSS-low cycle + 1, for exactly 1 cycle.
- Counters: half-period counter is $clog2(CLOCK_DIVIDER) bits, wrapping at D−1; bit counter is 6 bits, 0..31.

## Configuration
- SPI_MASTER_READBACK_EN defined: MISO capture, o_Sample and o_SampleValid behave as above.
- Not defined: no capture register; o_Sample tied 0, o_SampleValid tied 0, i_SPI_MISO unused. Frame timing is identical.

## Structure
- Shared package spi_pkg: SPI_FRAME_BITS = 32, SPI_MIN_CLOCK_DIVIDER = 4, and the state enum (IDLE, SETUP, SHIFT, HOLD, GAP).
- Sub-module spi_master_clkdiv: half-period tick counter, cleared on entry to each state, emitting a one-cycle tick every D cycles.
- Elaboration-time assertion: CLOCK_DIVIDER ≥ SPI_MIN_CLOCK_DIVIDER.

## Test plan
- D = 4, command 0x0012/0xABCD → MOSI sampled on SCK falling edges reads 0x0012ABCD MSB first; exactly 32 SCK pulses; NSS low for 264 cycles, then high for 4.
- MISO looped to MOSI, command 0x1234/0x5678 → o_SampleValid pulses once, o_Sample = 0x5678.
- Valid held high for 3 commands → 3 frames, each separated by ≥ 4 cycles NSS high; ready high only in IDLE; 3 sample pulses.
- Inputs changed to 0xFFFF/0xFFFF one cycle after handshake of 0x0001/0x0002 → frame still sends 0x00010002.
- Reset asserted mid-SHIFT at bit 10 → next cycle NSS = 1, SCK = 0, MOSI = 0, ready = 1; no o_SampleValid pulse.
- Built without SPI_MASTER_READBACK_EN, MISO toggling → o_Sample stays 0, o_SampleValid never asserts, MOSI and NSS identical to the first scenario.
